// File: rtl/mux2to1_4bit_arbiter_if.sv
// ============================================================================
// Module      : mux2to1_4bit_arbiter_if
// Description : Request/grant and mux-control bundle between the two
//               requesters and the quad 2-to-1 mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux2to1_4bit_arbiter_if;
    logic REQ_A;
    logic REQ_B;
    logic S;
    logic E;
    logic GNT_A;
    logic GNT_B;
    logic BUSY;

    // Requester side: raises requests, observes grants and mux control
    modport master (
        output REQ_A,
        output REQ_B,
        input  S,
        input  E,
        input  GNT_A,
        input  GNT_B,
        input  BUSY
    );

    // Arbiter side
    modport slave (
        input  REQ_A,
        input  REQ_B,
        output S,
        output E,
        output GNT_A,
        output GNT_B,
        output BUSY
    );
endinterface

`default_nettype wire

// File: rtl/mux2to1_4bit_arbiter.sv
// ============================================================================
// Module      : mux2to1_4bit_arbiter
// Description : Round-robin owner arbiter for a quad 2-to-1 mux with a
//               one-cycle turnaround; optional hold limit via the
//               MUX_ARB_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2to1_4bit_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    mux2to1_4bit_arbiter_if.slave       io_bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OWN_A = 2'd1;
    localparam logic [1:0] c_OWN_B = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    localparam logic c_SIDE_A = 1'b0;
    localparam logic c_SIDE_B = 1'b1;

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_cfg_check
        $error("mux2to1_4bit_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last;
    logic       r_s;
    logic       w_timeout;
    logic       w_enter_own;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_HOLD_TOP = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_hold_cnt;

    // Pre-empt only when the other side is actually waiting
    assign w_timeout = io_bus.REQ_A && io_bus.REQ_B && (r_hold_cnt == c_HOLD_TOP);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_cnt <= '0;
        end else if (w_enter_own) begin
            r_hold_cnt <= '0;
        end else if (((r_state == c_OWN_A) || (r_state == c_OWN_B)) &&
                     (r_hold_cnt != c_HOLD_TOP)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (io_bus.REQ_A && io_bus.REQ_B) begin
                    w_next = (r_last == c_SIDE_B) ? c_OWN_A : c_OWN_B;
                end else if (io_bus.REQ_A) begin
                    w_next = c_OWN_A;
                end else if (io_bus.REQ_B) begin
                    w_next = c_OWN_B;
                end
            end
            c_OWN_A: begin
                if (!io_bus.REQ_A || w_timeout) begin
                    w_next = c_GAP;
                end
            end
            c_OWN_B: begin
                if (!io_bus.REQ_B || w_timeout) begin
                    w_next = c_GAP;
                end
            end
            default: begin
                // Turnaround: the side not served last gets first refusal
                if (r_last == c_SIDE_A) begin
                    if (io_bus.REQ_B)      w_next = c_OWN_B;
                    else if (io_bus.REQ_A) w_next = c_OWN_A;
                    else                   w_next = c_IDLE;
                end else begin
                    if (io_bus.REQ_A)      w_next = c_OWN_A;
                    else if (io_bus.REQ_B) w_next = c_OWN_B;
                    else                   w_next = c_IDLE;
                end
            end
        endcase
    end

    assign w_enter_own = ((w_next == c_OWN_A) || (w_next == c_OWN_B)) && (w_next != r_state);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_last  <= c_SIDE_B;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_enter_own) begin
                r_last <= (w_next == c_OWN_B);
                r_s    <= (w_next == c_OWN_B);
            end
        end
    end

    assign io_bus.GNT_A = (r_state == c_OWN_A);
    assign io_bus.GNT_B = (r_state == c_OWN_B);
    assign io_bus.BUSY  = io_bus.GNT_A || io_bus.GNT_B;
    assign io_bus.E     = !(io_bus.GNT_A || io_bus.GNT_B);
    assign io_bus.S     = r_s;

endmodule

`default_nettype wire
